// File: rtl/wash_pkg.sv
// Shared types and constants for the wash sequencer: phase encoding,
// step/mode indices and the per-program phase duration table.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_GAP   = 3'd5,
    PH_PAUSE = 3'd6,
    PH_DONE  = 3'd7
  } phase_e;

  localparam logic [1:0] STEP_FILL  = 2'd0;
  localparam logic [1:0] STEP_WASH  = 2'd1;
  localparam logic [1:0] STEP_RINSE = 2'd2;
  localparam logic [1:0] STEP_SPIN  = 2'd3;

  localparam logic [1:0] MODE_QUICK  = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_HEAVY  = 2'd2;
  localparam logic [1:0] MODE_RINSE  = 2'd3;

  // DUR[mode][step], in step-timer ticks
  localparam logic [15:0] DUR [4][4] = '{
    '{16'd5,  16'd20,  16'd10, 16'd10},
    '{16'd10, 16'd60,  16'd30, 16'd20},
    '{16'd15, 16'd120, 16'd60, 16'd40},
    '{16'd10, 16'd0,   16'd30, 16'd20}
  };

  function automatic logic is_active(input phase_e ph);
    return (ph == PH_FILL) || (ph == PH_WASH) || (ph == PH_RINSE) || (ph == PH_SPIN);
  endfunction

  function automatic logic [1:0] step_of(input phase_e ph);
    case (ph)
      PH_WASH:  return STEP_WASH;
      PH_RINSE: return STEP_RINSE;
      PH_SPIN:  return STEP_SPIN;
      default:  return STEP_FILL;
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e ph, input logic [1:0] mode);
    case (ph)
      PH_FILL:  return (mode == MODE_RINSE) ? PH_RINSE : PH_WASH;
      PH_WASH:  return PH_RINSE;
      PH_RINSE: return PH_SPIN;
      default:  return PH_DONE;
    endcase
  endfunction

endpackage

// File: rtl/wash_edge_det.sv
// Registered rising-edge detector: rise is high for one cycle, one clock
// after din is first sampled high.
module wash_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      rise   <= '0;
    end else begin
      prev_q <= din;
      rise   <= din & ~prev_q;
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Wash program sequencer: steps FILL/WASH/RINSE/SPIN through an external
// step timer, with inter-phase gaps, pause/door interlock and resume.
//
// state | meaning
// IDLE  | waiting for a go edge with the door closed
// FILL  | timer running step 0
// WASH  | timer running step 1 (skipped in rinse-only)
// RINSE | timer running step 2
// SPIN  | timer running step 3
// GAP   | timer held off so it clears; outputs show the pending phase
// PAUSE | pause or door open; the phase to resume is held in tgt_q
// DONE  | program finished; waits for go to drop
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_go,
  input  logic          i_pause,
  input  logic          i_door_open,
  input  logic [1:0]    i_mode,
  input  logic [3:0]    i_resp,
  output logic          o_start,
  output logic [DW-1:0] o_state,
  output logic [1:0]    o_step,
  output logic [2:0]    o_phase,
  output logic          o_busy,
  output logic          o_done
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  phase_e        state_q, state_d;
  phase_e        tgt_q, tgt_d;
  logic [1:0]    mode_q, mode_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          settled_q;
  logic          go_rise;
  logic [3:0]    resp_rise;

  wash_edge_det #(.W(1)) u_go_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i_go),
    .rise  (go_rise)
  );

  wash_edge_det #(.W(4)) u_resp_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i_resp),
    .rise  (resp_rise)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    case (state_q)
      PH_IDLE: begin
        if (go_rise && !i_door_open) begin
          state_d = PH_FILL;
          mode_d  = i_mode;
        end
      end
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
        if (i_pause || i_door_open) begin
          state_d = PH_PAUSE;
          tgt_d   = state_q;
        // settled_q masks an edge that was already present at phase entry
        end else if (settled_q && resp_rise[step_of(state_q)]) begin
          if (state_q == PH_SPIN) begin
            state_d = PH_DONE;
            tgt_d   = PH_IDLE;
          end else begin
            state_d = PH_GAP;
            tgt_d   = next_phase(state_q, mode_q);
            gap_d   = GW'(GAP_CYCLES);
          end
        end
      end
      PH_GAP: begin
        if (i_door_open) begin
          state_d = PH_PAUSE;
          gap_d   = '0;
        end else if (gap_q <= GW'(1)) begin
          state_d = tgt_q;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      PH_PAUSE: begin
        if (!i_pause && !i_door_open) begin
          state_d = PH_GAP;
          gap_d   = GW'(GAP_CYCLES);
        end
      end
      PH_DONE: begin
        if (!i_go) state_d = PH_IDLE;
      end
      default: state_d = PH_IDLE;
    endcase
  end

  phase_e        view_ph;
  logic          start_d, busy_d, done_d;
  logic [1:0]    step_d;
  logic [DW-1:0] dur_d;

  always_comb begin
    view_ph = is_active(state_d) ? state_d : tgt_d;
    start_d = is_active(state_d);
    busy_d  = (state_d != PH_IDLE) && (state_d != PH_DONE);
    done_d  = (state_d == PH_DONE) && (state_q != PH_DONE);
    step_d  = '0;
    dur_d   = '0;
    if (busy_d) begin
      step_d = step_of(view_ph);
      dur_d  = DW'(DUR[mode_d][step_of(view_ph)]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PH_IDLE;
      tgt_q     <= PH_IDLE;
      mode_q    <= '0;
      gap_q     <= '0;
      settled_q <= 1'b0;
      o_start   <= 1'b0;
      o_state   <= '0;
      o_step    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      settled_q <= (state_d == state_q);
      o_start   <= start_d;
      o_state   <= dur_d;
      o_step    <= step_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

  assign o_phase = state_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: program runs in several modes, pause,
// door interlock, held response bits and mid-phase reset.
module tb_wash_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_go, i_pause, i_door_open;
  logic [1:0]  i_mode;
  logic [3:0]  i_resp;
  logic        o_start;
  logic [15:0] o_state;
  logic [1:0]  o_step;
  logic [2:0]  o_phase;
  logic        o_busy, o_done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int wash_cnt = 0;
  int done_snap, wash_snap;

  wash_sequencer #(.GAP_CYCLES(16), .DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_go        (i_go),
    .i_pause     (i_pause),
    .i_door_open (i_door_open),
    .i_mode      (i_mode),
    .i_resp      (i_resp),
    .o_start     (o_start),
    .o_state     (o_state),
    .o_step      (o_step),
    .o_phase     (o_phase),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_phase == 3'd2) wash_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the first GAP cycle; checks the full 16-cycle gap, then the phase.
  task automatic gap_then(input string tag, input logic [2:0] ph, input logic [15:0] dur);
    step(15);
    chk({tag, "_gap_last"}, o_phase, 5);
    chk({tag, "_gap_nostart"}, o_start, 0);
    step(1);
    chk({tag, "_phase"}, o_phase, ph);
    chk({tag, "_dur"}, o_state, dur);
    chk({tag, "_start"}, o_start, 1);
  endtask

  initial begin
    rst_n = 1'b0; i_go = 1'b0; i_pause = 1'b0; i_door_open = 1'b0;
    i_mode = 2'd1; i_resp = 4'h0;
    step(2);
    chk("rst_phase", o_phase, 0);
    chk("rst_start", o_start, 0);
    chk("rst_state", o_state, 0);
    chk("rst_step", o_step, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst_n = 1'b1;
    step(1);

    // mode 1 full run
    done_snap = done_cnt;
    i_go = 1'b1; step(2);
    chk("m1_fill", o_phase, 1);
    chk("m1_fill_dur", o_state, 10);
    chk("m1_fill_step", o_step, 0);
    chk("m1_fill_busy", o_busy, 1);
    chk("m1_fill_start", o_start, 1);
    i_go = 1'b0; step(1); i_go = 1'b1; step(2);
    chk("go_while_busy", o_phase, 1);
    i_resp[0] = 1'b1; step(2);
    chk("m1_gap1", o_phase, 5);
    chk("m1_gap1_step", o_step, 1);
    chk("m1_gap1_dur", o_state, 60);
    gap_then("m1_wash", 3'd2, 16'd60);
    i_resp[1] = 1'b1; step(2);
    chk("m1_gap2_step", o_step, 2);
    gap_then("m1_rinse", 3'd3, 16'd30);
    i_resp[2] = 1'b1; step(2);
    chk("m1_gap3_step", o_step, 3);
    gap_then("m1_spin", 3'd4, 16'd20);
    i_resp[3] = 1'b1; step(2);
    chk("m1_done", o_phase, 7);
    chk("m1_done_pulse", o_done, 1);
    chk("m1_done_start", o_start, 0);
    chk("m1_done_busy", o_busy, 0);
    step(1);
    chk("m1_done_one_cycle", o_done, 0);
    chk("m1_done_hold", o_phase, 7);
    i_go = 1'b0; step(1);
    chk("m1_idle", o_phase, 0);
    chk("m1_done_count", done_cnt - done_snap, 1);
    i_resp = 4'h0; step(1);

    // mode 3 rinse-only
    wash_snap = wash_cnt;
    i_mode = 2'd3; i_go = 1'b1; step(2);
    chk("m3_fill", o_phase, 1);
    i_resp[0] = 1'b1; step(2);
    chk("m3_gap_step", o_step, 2);
    chk("m3_gap_dur", o_state, 30);
    gap_then("m3_rinse", 3'd3, 16'd30);
    chk("m3_rinse_step", o_step, 2);
    i_resp[2] = 1'b1; step(2);
    chk("m3_gap2_step", o_step, 3);
    gap_then("m3_spin", 3'd4, 16'd20);
    i_resp[3] = 1'b1; step(2);
    chk("m3_done", o_phase, 7);
    chk("m3_no_wash", wash_cnt - wash_snap, 0);
    i_go = 1'b0; i_resp = 4'h0; step(2);

    // pause in WASH, then completion coinciding with pause
    i_mode = 2'd1; i_go = 1'b1; step(2);
    i_resp[0] = 1'b1; step(2);
    gap_then("p_wash", 3'd2, 16'd60);
    i_pause = 1'b1; step(1);
    chk("p_pause", o_phase, 6);
    chk("p_pause_start", o_start, 0);
    step(3);
    chk("p_pause_hold", o_phase, 6);
    i_pause = 1'b0; step(1);
    chk("p_resume_gap", o_phase, 5);
    chk("p_resume_step", o_step, 1);
    gap_then("p_rewash", 3'd2, 16'd60);
    i_resp[1] = 1'b1; step(1);
    i_pause = 1'b1; step(1);
    chk("race_pause_wins", o_phase, 6);
    i_pause = 1'b0; step(1);
    chk("race_gap", o_phase, 5);
    gap_then("race_repeat", 3'd2, 16'd60);
    step(5);
    chk("race_held_resp", o_phase, 2);
    i_resp[1] = 1'b0; step(1);
    i_resp[1] = 1'b1; step(2);
    chk("race_toggle_end", o_phase, 5);
    chk("race_toggle_step", o_step, 2);
    rst_n = 1'b0; i_go = 1'b0; i_resp = 4'h0; step(1);
    rst_n = 1'b1; step(1);

    // go with door open
    i_door_open = 1'b1; i_go = 1'b1; step(4);
    chk("door_go_phase", o_phase, 0);
    chk("door_go_busy", o_busy, 0);
    i_go = 1'b0; i_door_open = 1'b0; step(1);

    // mode 0, response bit held across RINSE entry, door open in GAP
    i_mode = 2'd0; i_resp[2] = 1'b1; step(1);
    i_go = 1'b1; step(2);
    chk("m0_fill_dur", o_state, 5);
    i_resp[0] = 1'b1; step(2);
    chk("m0_gap_dur", o_state, 20);
    gap_then("m0_wash", 3'd2, 16'd20);
    i_resp[1] = 1'b1; step(2);
    chk("m0_gap2_dur", o_state, 10);
    step(3);
    i_door_open = 1'b1; step(1);
    chk("gap_door_pause", o_phase, 6);
    chk("gap_door_start", o_start, 0);
    step(2);
    i_door_open = 1'b0; step(1);
    chk("gap_door_resume", o_phase, 5);
    chk("gap_door_step", o_step, 2);
    gap_then("m0_rinse", 3'd3, 16'd10);
    step(5);
    chk("held_resp_rinse", o_phase, 3);
    i_resp[2] = 1'b0; step(1);
    i_resp[2] = 1'b1; step(2);
    chk("held_resp_end", o_phase, 5);
    chk("held_resp_step", o_step, 3);
    gap_then("m0_spin", 3'd4, 16'd10);

    // asynchronous reset mid-SPIN
    done_snap = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", o_phase, 0);
    chk("arst_start", o_start, 0);
    chk("arst_state", o_state, 0);
    chk("arst_step", o_step, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    i_go = 1'b0; i_resp = 4'h0;
    step(3);
    chk("arst_no_done", done_cnt - done_snap, 0);
    rst_n = 1'b1; step(2);
    chk("arst_idle", o_phase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 16, clk cycles o_start is held low between phases so the slow-clocked step timer clears.
REQ-002 Parameter DW, default 16, width of the duration bus.
REQ-003 Port clk  in  1  system clock.
REQ-004 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port i_go  in  1  run request; level, edge-detected internally.
REQ-006 Port i_pause  in  1  pause request; level.
REQ-007 Port i_door_open  in  1  door interlock; level.
REQ-008 Port i_mode  in  2  program select: 0 quick, 1 normal, 2 heavy, 3 rinse-only; sampled on accepted go.
REQ-009 Port i_resp  in  4  per-step completion flags from the step timer; sticky.
REQ-010 Port o_start  out  1  timer enable.
REQ-011 Port o_state  out  DW  duration for the current phase, in timer ticks.
REQ-012 Port o_step  out  2  timer step index: FILL 0, WASH 1, RINSE 2, SPIN 3.
REQ-013 Port o_phase  out  3  encoded FSM state.
REQ-014 Port o_busy  out  1  high in any state other than IDLE or DONE.
REQ-015 Port o_done  out  1  one-cycle pulse on entry to DONE.

Function
REQ-016 FSM states SHALL be IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, GAP=5, PAUSE=6, DONE=7, output on o_phase.
REQ-017 IDLE->FILL on a rising edge of i_go with i_door_open=0; i_mode is latched into mode_q on the same edge; the go edge is ignored if the door is open.
REQ-018 Phase order SHALL be FILL->WASH->RINSE->SPIN; mode 3 skips WASH (FILL->RINSE).
REQ-019 Every phase-to-phase move SHALL pass through GAP for exactly GAP_CYCLES cycles with o_start=0; o_step/o_state already show the next phase during GAP.
REQ-020 In FILL/WASH/RINSE/SPIN, o_start=1 and o_state=DUR[mode_q][o_step].
REQ-021 A phase ends on a 0->1 transition of i_resp[o_step], registered one cycle, so the FSM moves one cycle after the edge.
REQ-022 An i_resp bit already high at phase entry SHALL NOT end the phase.
REQ-023 After SPIN completes, FSM goes to DONE: o_done pulses for one cycle and o_start=0.
REQ-024 DONE->IDLE when i_go is low.
REQ-025 i_pause=1 or i_door_open=1 in any active phase SHALL move to PAUSE next cycle with o_start=0, saving the phase.
REQ-026 PAUSE->GAP then the saved phase when i_pause=0 and i_door_open=0; the phase timer restarts from zero.
REQ-027 i_door_open during GAP SHALL enter PAUSE; the saved phase is the pending next phase.
REQ-028 If a completion edge and a pause arrive in the same cycle, pause wins and the phase is repeated on resume.
REQ-029 A rising edge of i_go while busy SHALL be ignored.
REQ-030 The GAP counter is ceil(log2(GAP_CYCLES+1)) bits, counts down, and has no wrap.
REQ-031 All outputs are registered.

Reset
REQ-032 With rst_n low, all outputs are 0: state IDLE, o_start 0, o_state 0, o_step 0, o_phase 0, o_busy 0, o_done 0; mode_q, the saved phase, the GAP counter and the edge registers are all 0.
REQ-033 Reset mid-phase aborts immediately to IDLE; no o_done is produced.

Structure
REQ-034 Package wash_pkg SHALL hold the phase enum, step index constants, mode constants and the DUR[4][4] duration table (quick 5/20/10/10, normal 10/60/30/20, heavy 15/120/60/40, rinse-only 10/0/30/20).
REQ-035 One sub-module, wash_edge_det, SHALL provide a registered rising-edge detector, instantiated for i_go and for the 4-bit i_resp.

Verification
REQ-036 Mode 1, go edge, i_resp bits raised in sequence -> phases 1,5,2,5,3,5,4,7; o_state 10,60,30,20; o_done one pulse.
REQ-037 Mode 3 -> WASH never entered; o_step sequence 0,2,3.
REQ-038 i_pause during WASH -> PAUSE next cycle with o_start=0; release -> GAP of 16 cycles, then WASH with o_state=60.
REQ-039 Go edge with i_door_open=1 -> stays IDLE; o_busy remains 0.
REQ-040 i_resp[2] held high before RINSE entry -> RINSE does not end until that bit is toggled 0->1.
REQ-041 rst_n low during SPIN -> all outputs 0 asynchronously; no o_done pulse.
